// File: rtl/m_call_ret_ctrl_if.sv
// Stack-side handshake bundle for the call/return controller.
// master: controller side; slave: return-stack side.
interface m_call_ret_ctrl_if #(
    parameter int WORD = 16
);
    logic            stk_push;
    logic            stk_pop;
    logic [WORD:0]   stk_data_o;
    logic [WORD:0]   stk_data_i;
    logic            stk_ack;
    logic            stk_full;
    logic            stk_empty;

    modport master (
        output stk_push,
        output stk_pop,
        output stk_data_o,
        input  stk_data_i,
        input  stk_ack,
        input  stk_full,
        input  stk_empty
    );

    modport slave (
        input  stk_push,
        input  stk_pop,
        input  stk_data_o,
        output stk_data_i,
        output stk_ack,
        output stk_full,
        output stk_empty
    );
endinterface

// File: rtl/m_call_ret_ctrl.sv
// Call/return sequencer: pushes return frames, pops them back,
// and redirects the program counter, with fault trapping.
module m_call_ret_ctrl #(
    parameter int WORD    = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         call,
    input  logic                         ret,
    input  logic [WORD-1:0]              pc_i,
    input  logic [WORD-1:0]              target_i,
    input  logic                         clr_fault,
    m_call_ret_ctrl_if.master            stk,
    output logic                         pc_load,
    output logic [WORD-1:0]              pc_o,
    output logic                         busy,
    output logic                         fault,
    output logic [2:0]                   fault_code,
    output logic [$clog2(DEPTH+1)-1:0]   depth
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_OVERFLOW = 3'd1;
    localparam logic [2:0] FC_UNDERFL  = 3'd2;
    localparam logic [2:0] FC_CORRUPT  = 3'd3;
    localparam logic [2:0] FC_TIMEOUT  = 3'd4;
    localparam logic [2:0] FC_CONFLICT = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        PUSH_REQ,
        POP_REQ,
        LOAD,
        FAULT
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic [WORD-1:0] pc_q, pc_d;
    logic [2:0]      code_q, code_d;
    logic [WORD-1:0] ret_addr_q, ret_addr_d;
    logic [WORD-1:0] target_q, target_d;
    logic [CW-1:0]   wait_q, wait_d;

    logic            push_s;
    logic            pop_s;
    logic [WORD:0]   data_s;
    logic            load_s;
    logic            busy_s;
    logic            fault_s;

    // State register; reset aborts any in-flight request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers that travel with the FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth_q    <= '0;
            pc_q       <= '0;
            code_q     <= FC_NONE;
            ret_addr_q <= '0;
            target_q   <= '0;
            wait_q     <= '0;
        end else begin
            depth_q    <= depth_d;
            pc_q       <= pc_d;
            code_q     <= code_d;
            ret_addr_q <= ret_addr_d;
            target_q   <= target_d;
            wait_q     <= wait_d;
        end
    end

    // Next-state and datapath update decisions.
    always_comb begin
        state_d    = state_q;
        depth_d    = depth_q;
        pc_d       = pc_q;
        code_d     = code_q;
        ret_addr_d = ret_addr_q;
        target_d   = target_q;
        wait_d     = wait_q;
        unique case (state_q)
            IDLE: begin
                if (call && ret) begin
                    state_d = FAULT;
                    code_d  = FC_CONFLICT;
                end else if (call) begin
                    if (depth_q == DW'(DEPTH) || stk.stk_full) begin
                        state_d = FAULT;
                        code_d  = FC_OVERFLOW;
                    end else begin
                        ret_addr_d = pc_i + WORD'(1);
                        target_d   = target_i;
                        wait_d     = '0;
                        state_d    = PUSH_REQ;
                    end
                end else if (ret) begin
                    if (depth_q == '0 || stk.stk_empty) begin
                        state_d = FAULT;
                        code_d  = FC_UNDERFL;
                    end else begin
                        wait_d  = '0;
                        state_d = POP_REQ;
                    end
                end
            end
            PUSH_REQ: begin
                if (stk.stk_ack) begin
                    depth_d = depth_q + DW'(1);
                    pc_d    = target_q;
                    state_d = LOAD;
                end else if (wait_q == CW'(TIMEOUT - 1)) begin
                    wait_d  = '0;
                    code_d  = FC_TIMEOUT;
                    state_d = FAULT;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            POP_REQ: begin
                if (stk.stk_ack) begin
                    depth_d = depth_q - DW'(1);
                    if (stk.stk_data_i[WORD]) begin
                        pc_d    = stk.stk_data_i[WORD-1:0];
                        state_d = LOAD;
                    end else begin
                        code_d  = FC_CORRUPT;
                        state_d = FAULT;
                    end
                end else if (wait_q == CW'(TIMEOUT - 1)) begin
                    wait_d  = '0;
                    code_d  = FC_TIMEOUT;
                    state_d = FAULT;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            LOAD: begin
                state_d = IDLE;
            end
            FAULT: begin
                if (clr_fault) begin
                    code_d  = FC_NONE;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        push_s  = 1'b0;
        pop_s   = 1'b0;
        data_s  = '0;
        load_s  = 1'b0;
        busy_s  = 1'b1;
        fault_s = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy_s = 1'b0;
            end
            PUSH_REQ: begin
                push_s = 1'b1;
                data_s = {1'b1, ret_addr_q};
            end
            POP_REQ: begin
                pop_s = 1'b1;
            end
            LOAD: begin
                load_s = 1'b1;
            end
            FAULT: begin
                fault_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    assign stk.stk_push   = push_s;
    assign stk.stk_pop    = pop_s;
    assign stk.stk_data_o = data_s;
    assign pc_load        = load_s;
    assign busy           = busy_s;
    assign fault          = fault_s;
    assign pc_o           = pc_q;
    assign fault_code     = code_q;
    assign depth          = depth_q;
endmodule

// File: tb/tb_m_call_ret_ctrl.sv
// Directed bench for m_call_ret_ctrl: call, return, overflow,
// underflow, conflict, timeout, reset abort and corrupt frame.
module tb_m_call_ret_ctrl;
    localparam int WORD = 16;

    logic            clk;
    logic            reset;
    logic            call;
    logic            ret;
    logic [WORD-1:0] pc_i;
    logic [WORD-1:0] target_i;
    logic            clr_fault;
    logic            pc_load;
    logic [WORD-1:0] pc_o;
    logic            busy;
    logic            fault;
    logic [2:0]      fault_code;
    logic [2:0]      depth;

    int n_cmp;
    int n_bad;

    m_call_ret_ctrl_if #(.WORD(WORD)) stk ();

    m_call_ret_ctrl #(
        .WORD(WORD),
        .DEPTH(4),
        .TIMEOUT(15)
    ) dut (
        .clk(clk),
        .reset(reset),
        .call(call),
        .ret(ret),
        .pc_i(pc_i),
        .target_i(target_i),
        .clr_fault(clr_fault),
        .stk(stk.master),
        .pc_load(pc_load),
        .pc_o(pc_o),
        .busy(busy),
        .fault(fault),
        .fault_code(fault_code),
        .depth(depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        call = 1'b0;
        ret = 1'b0;
        pc_i = '0;
        target_i = '0;
        clr_fault = 1'b0;
        stk.stk_data_i = '0;
        stk.stk_ack = 1'b0;
        stk.stk_full = 1'b0;
        stk.stk_empty = 1'b0;
        #22;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_depth", 32'(depth), 32'h0);
        chk("rst_pc", 32'(pc_o), 32'h0);
        chk("rst_code", 32'(fault_code), 32'h0);
        chk("rst_push", 32'(stk.stk_push), 32'h0);
        chk("rst_data", 32'(stk.stk_data_o), 32'h0);
        reset = 1'b1;
        tick();

        // call with ack one cycle late
        call = 1'b1;
        pc_i = 16'h0010;
        target_i = 16'h0200;
        tick();
        call = 1'b0;
        chk("call_push", 32'(stk.stk_push), 32'h1);
        chk("call_data", 32'(stk.stk_data_o), 32'h10011);
        chk("call_busy", 32'(busy), 32'h1);
        tick();
        chk("call_hold", 32'(stk.stk_push), 32'h1);
        chk("call_pop0", 32'(stk.stk_pop), 32'h0);
        stk.stk_ack = 1'b1;
        tick();
        stk.stk_ack = 1'b0;
        chk("call_load", 32'(pc_load), 32'h1);
        chk("call_pc", 32'(pc_o), 32'h0200);
        chk("call_depth", 32'(depth), 32'h1);
        chk("call_push0", 32'(stk.stk_push), 32'h0);
        tick();
        chk("call_idle", 32'(busy), 32'h0);
        chk("call_load0", 32'(pc_load), 32'h0);
        chk("call_pchold", 32'(pc_o), 32'h0200);

        // matching return
        ret = 1'b1;
        tick();
        ret = 1'b0;
        chk("ret_pop", 32'(stk.stk_pop), 32'h1);
        chk("ret_push0", 32'(stk.stk_push), 32'h0);
        stk.stk_data_i = 17'h10011;
        stk.stk_ack = 1'b1;
        tick();
        stk.stk_ack = 1'b0;
        chk("ret_load", 32'(pc_load), 32'h1);
        chk("ret_pc", 32'(pc_o), 32'h0011);
        chk("ret_depth", 32'(depth), 32'h0);
        tick();

        // four calls with same-cycle ack
        for (int i = 0; i < 4; i++) begin
            call = 1'b1;
            pc_i = 16'h0100 + 16'(i);
            target_i = 16'h0400 + 16'(i);
            tick();
            call = 1'b0;
            chk("fill_push", 32'(stk.stk_push), 32'h1);
            stk.stk_ack = 1'b1;
            tick();
            stk.stk_ack = 1'b0;
            chk("fill_load", 32'(pc_load), 32'h1);
            chk("fill_pc", 32'(pc_o), 32'h0400 + 32'(i));
            tick();
        end
        chk("fill_depth", 32'(depth), 32'h4);
        call = 1'b1;
        tick();
        call = 1'b0;
        chk("ovf_push", 32'(stk.stk_push), 32'h0);
        chk("ovf_fault", 32'(fault), 32'h1);
        chk("ovf_code", 32'(fault_code), 32'h1);
        tick();
        chk("ovf_sticky", 32'(fault), 32'h1);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        chk("clr_busy", 32'(busy), 32'h0);
        chk("clr_code", 32'(fault_code), 32'h0);
        chk("clr_depth", 32'(depth), 32'h4);

        // drain the four frames
        for (int i = 3; i >= 0; i--) begin
            ret = 1'b1;
            tick();
            ret = 1'b0;
            stk.stk_data_i = 17'h10101 + 17'(i);
            stk.stk_ack = 1'b1;
            tick();
            stk.stk_ack = 1'b0;
            chk("drain_pc", 32'(pc_o), 32'h0101 + 32'(i));
            tick();
        end
        chk("drain_depth", 32'(depth), 32'h0);

        // underflow
        ret = 1'b1;
        tick();
        ret = 1'b0;
        chk("unf_pop", 32'(stk.stk_pop), 32'h0);
        chk("unf_code", 32'(fault_code), 32'h2);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;

        // conflict
        call = 1'b1;
        ret = 1'b1;
        tick();
        call = 1'b0;
        ret = 1'b0;
        chk("cfl_code", 32'(fault_code), 32'h5);
        chk("cfl_push", 32'(stk.stk_push), 32'h0);
        chk("cfl_pop", 32'(stk.stk_pop), 32'h0);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;

        // timeout, with wrapping return address
        call = 1'b1;
        pc_i = 16'hFFFF;
        target_i = 16'h0300;
        tick();
        call = 1'b0;
        chk("wrap_data", 32'(stk.stk_data_o), 32'h10000);
        for (int i = 1; i < 15; i++) begin
            tick();
            chk("to_hold", 32'(stk.stk_push), 32'h1);
        end
        tick();
        chk("to_push", 32'(stk.stk_push), 32'h0);
        chk("to_code", 32'(fault_code), 32'h4);
        chk("to_depth", 32'(depth), 32'h0);
        chk("to_pc", 32'(pc_o), 32'h0101);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;

        // reset mid-push after one good call
        call = 1'b1;
        pc_i = 16'h0020;
        target_i = 16'h0500;
        tick();
        call = 1'b0;
        stk.stk_ack = 1'b1;
        tick();
        stk.stk_ack = 1'b0;
        tick();
        chk("pre_depth", 32'(depth), 32'h1);
        call = 1'b1;
        tick();
        call = 1'b0;
        chk("pre_push", 32'(stk.stk_push), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_push", 32'(stk.stk_push), 32'h0);
        chk("ar_data", 32'(stk.stk_data_o), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_depth", 32'(depth), 32'h0);
        chk("ar_pc", 32'(pc_o), 32'h0);
        #3;
        reset = 1'b1;
        tick();

        // corrupt frame
        call = 1'b1;
        pc_i = 16'h0030;
        target_i = 16'h0600;
        tick();
        call = 1'b0;
        stk.stk_ack = 1'b1;
        tick();
        stk.stk_ack = 1'b0;
        tick();
        ret = 1'b1;
        tick();
        ret = 1'b0;
        stk.stk_data_i = 17'h00055;
        stk.stk_ack = 1'b1;
        tick();
        stk.stk_ack = 1'b0;
        chk("bad_code", 32'(fault_code), 32'h3);
        chk("bad_depth", 32'(depth), 32'h0);
        chk("bad_load", 32'(pc_load), 32'h0);
        chk("bad_pc", 32'(pc_o), 32'h0600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
